// File: rtl/pgm_block_if.sv
// Stream and config channel interfaces for the packet generator stage.

// Packet stream: PHV + data words + verdict, with almost-full back-pressure
interface pgm_stream_if;
  logic [1023:0] phv;
  logic          phv_wr;
  logic          phv_alf;
  logic [133:0]  data;
  logic          data_wr;
  logic          valid;
  logic          valid_wr;
  logic          alf;

  modport master (
    output phv, phv_wr, data, data_wr, valid, valid_wr,
    input  phv_alf, alf
  );

  modport slave (
    input  phv, phv_wr, data, data_wr, valid, valid_wr,
    output phv_alf, alf
  );
endinterface

// Single-word config channel with ready from the receiver
interface pgm_cfg_if;
  logic [133:0] data;
  logic         data_wr;
  logic         ready;

  modport master (
    output data, data_wr,
    input  ready
  );

  modport slave (
    input  data, data_wr,
    output ready
  );
endinterface

// File: rtl/pgm_block.sv
// Packet generator: buffers one packet plus PHV, replays it max(GEN_CNT,1)
// times downstream, and handles GEN_CNT writes on the config channel.
module pgm_block #(
  parameter logic [7:0]  MODULE_ID = 8'd61,
  parameter int unsigned BUF_DEPTH = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  pgm_stream_if.slave   in_pgm,
  pgm_stream_if.master  out_pgm,
  pgm_cfg_if.slave      cin_pgm,
  pgm_cfg_if.master     cout_pgm,
  output logic          out_pgm_sent_start_flag,
  output logic          out_pgm_sent_finish_flag
);

  localparam int unsigned AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RECV, WAIT, SEND} state_t;

  state_t          state, state_n;
  logic [133:0]    mem [BUF_DEPTH];
  logic [CW-1:0]   wr_cnt, wr_cnt_n;
  logic [AW-1:0]   rd_ptr, rd_ptr_n;
  logic [AW-1:0]   last_idx, last_idx_n;
  logic [15:0]     gen_cnt;
  logic [15:0]     copies, copies_n;
  logic            first, first_n;
  logic [1023:0]   phv_q;

  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic            overflow;
  logic            verdict;
  logic            emit;
  logic            head_in;
  logic            alf_n;
  logic [133:0]    data_n;
  logic            data_wr_n;
  logic            phv_wr_n;
  logic            valid_wr_n;
  logic            start_n;
  logic            finish_n;

  logic            cfg_take;
  logic            cfg_hit;

  assign head_in = in_pgm.data_wr && (in_pgm.data[133:132] == 2'b01);
  assign alf_n   = (state_n == WAIT) || (state_n == SEND);

  // State register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= IDLE;
    else       state <= state_n;
  end

  // Next state, buffer write control and output word selection
  always_comb begin
    state_n    = state;
    wr_cnt_n   = wr_cnt;
    rd_ptr_n   = rd_ptr;
    last_idx_n = last_idx;
    copies_n   = copies;
    first_n    = first;
    mem_we     = 1'b0;
    mem_addr   = '0;
    overflow   = 1'b0;
    emit       = 1'b0;
    data_n     = '0;
    data_wr_n  = 1'b0;
    phv_wr_n   = 1'b0;
    valid_wr_n = 1'b0;
    start_n    = 1'b0;
    finish_n   = 1'b0;

    case (state)
      IDLE: begin
        if (head_in) begin
          mem_we   = 1'b1;
          mem_addr = '0;
          wr_cnt_n = CW'(1);
          state_n  = RECV;
        end
      end
      RECV: begin
        if (in_pgm.data_wr) begin
          if (wr_cnt == CW'(BUF_DEPTH)) begin
            overflow = 1'b1;
            state_n  = IDLE;
          end else begin
            mem_we   = 1'b1;
            mem_addr = wr_cnt[AW-1:0];
            wr_cnt_n = wr_cnt + CW'(1);
          end
        end
      end
      WAIT: begin
        // Output must have been idle last cycle so copies are separated
        if (!out_pgm.alf && !out_pgm.phv_alf && !out_pgm.data_wr) begin
          emit     = 1'b1;
          phv_wr_n = 1'b1;
          start_n  = first;
          first_n  = 1'b0;
          state_n  = SEND;
        end
      end
      SEND: emit = 1'b1;
      default: state_n = IDLE;
    endcase

    verdict = in_pgm.valid_wr &&
              (((state == IDLE) && head_in) || ((state == RECV) && !overflow));
    if (verdict) begin
      if (in_pgm.valid) begin
        state_n    = WAIT;
        last_idx_n = AW'(wr_cnt_n - CW'(1));
        copies_n   = (gen_cnt == 16'd0) ? 16'd1 : gen_cnt;
        first_n    = 1'b1;
        rd_ptr_n   = '0;
      end else begin
        state_n = IDLE;
      end
    end

    if (emit) begin
      data_n    = mem[rd_ptr];
      data_wr_n = 1'b1;
      if (rd_ptr == last_idx) begin
        valid_wr_n = 1'b1;
        rd_ptr_n   = '0;
        copies_n   = copies - 16'd1;
        if (copies == 16'd1) begin
          finish_n = 1'b1;
          state_n  = IDLE;
        end else begin
          state_n = WAIT;
        end
      end else begin
        rd_ptr_n = rd_ptr + AW'(1);
      end
    end
  end

  // Packet buffer storage
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[mem_addr] <= in_pgm.data;
    end
  end

  // Packet bookkeeping registers and PHV capture
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_cnt   <= '0;
      rd_ptr   <= '0;
      last_idx <= '0;
      copies   <= '0;
      first    <= 1'b0;
      phv_q    <= '0;
    end else begin
      wr_cnt   <= wr_cnt_n;
      rd_ptr   <= rd_ptr_n;
      last_idx <= last_idx_n;
      copies   <= copies_n;
      first    <= first_n;
      if (in_pgm.phv_wr && ((state == IDLE) || (state == RECV))) phv_q <= in_pgm.phv;
    end
  end

  // Registered downstream outputs, status flags and busy indications
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      out_pgm.data             <= '0;
      out_pgm.data_wr          <= 1'b0;
      out_pgm.phv              <= '0;
      out_pgm.phv_wr           <= 1'b0;
      out_pgm.valid            <= 1'b0;
      out_pgm.valid_wr         <= 1'b0;
      out_pgm_sent_start_flag  <= 1'b0;
      out_pgm_sent_finish_flag <= 1'b0;
      in_pgm.alf               <= 1'b0;
      in_pgm.phv_alf           <= 1'b0;
    end else begin
      out_pgm.data             <= data_n;
      out_pgm.data_wr          <= data_wr_n;
      out_pgm.phv_wr           <= phv_wr_n;
      if (phv_wr_n) out_pgm.phv <= phv_q;
      out_pgm.valid            <= valid_wr_n;
      out_pgm.valid_wr         <= valid_wr_n;
      out_pgm_sent_start_flag  <= start_n;
      out_pgm_sent_finish_flag <= finish_n;
      in_pgm.alf               <= alf_n;
      in_pgm.phv_alf           <= alf_n;
    end
  end

  assign cin_pgm.ready = cout_pgm.ready;
  assign cfg_take = cin_pgm.data_wr && cout_pgm.ready;
  assign cfg_hit  = cin_pgm.data[127] && (cin_pgm.data[126:124] == 3'b001) &&
                    (cin_pgm.data[103:96] == MODULE_ID);

  // Config: consume writes to this module, forward everything else
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      gen_cnt          <= '0;
      cout_pgm.data    <= '0;
      cout_pgm.data_wr <= 1'b0;
    end else begin
      cout_pgm.data_wr <= cfg_take && !cfg_hit;
      if (cfg_take && !cfg_hit) cout_pgm.data <= cin_pgm.data;
      if (cfg_take && cfg_hit && (cin_pgm.data[95:64] == 32'h0001_0001))
        gen_cnt <= cin_pgm.data[63:48];
    end
  end

endmodule

// File: tb/tb_pgm_block.sv
// Self-checking bench for pgm_block: directed config/packet scenarios plus
// randomized packets checked against a copy-count reference model.
module tb_pgm_block;

  logic clk = 1'b0;
  logic rst_n;
  logic start_flag, finish_flag;

  pgm_stream_if in_if ();
  pgm_stream_if out_if ();
  pgm_cfg_if    cin_if ();
  pgm_cfg_if    cout_if ();

  pgm_block dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .in_pgm                   (in_if),
    .out_pgm                  (out_if),
    .cin_pgm                  (cin_if),
    .cout_pgm                 (cout_if),
    .out_pgm_sent_start_flag  (start_flag),
    .out_pgm_sent_finish_flag (finish_flag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [133:0]  pkt_q [$];
  logic [133:0]  got_q [$];
  logic [1023:0] exp_phv;
  int phv_cnt, valid_cnt, start_cnt, finish_cnt, both_cnt, phv_bad, gap_bad;
  int first_head_cyc, tail_cyc;
  bit head_seen, prev_vwr;
  int model_gen;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n === 1'b0) begin
      if (out_if.data_wr) got_q.push_back(out_if.data);
      if (out_if.phv_wr) begin
        phv_cnt++;
        if (out_if.phv !== exp_phv) phv_bad++;
        if (prev_vwr) gap_bad++;
        if (!head_seen) begin
          head_seen = 1'b1;
          first_head_cyc = cyc;
        end
      end
      if (out_if.valid_wr && out_if.valid === 1'b1) valid_cnt++;
      if (start_flag) start_cnt++;
      if (finish_flag) finish_cnt++;
      if (start_flag && finish_flag) both_cnt++;
      prev_vwr = out_if.valid_wr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [133:0] rnd_word(input logic [1:0] t);
    logic [133:0] w;
    w[31:0]    = $urandom;
    w[63:32]   = $urandom;
    w[95:64]   = $urandom;
    w[127:96]  = $urandom;
    w[131:128] = 4'($urandom);
    w[133:132] = t;
    return w;
  endfunction

  function automatic logic [133:0] cfg_word(input logic [7:0] id, input logic [31:0] addr,
                                            input logic [31:0] wdata);
    logic [133:0] w;
    w = rnd_word(2'b00);
    w[127]     = 1'b1;
    w[126:124] = 3'b001;
    w[103:96]  = id;
    w[95:64]   = addr;
    w[63:32]   = wdata;
    return w;
  endfunction

  task automatic cfg_send(input logic [133:0] w, input bit rdy);
    cin_if.data    = w;
    cin_if.data_wr = 1'b1;
    cout_if.ready  = rdy;
    #1;
    check("cout_ready_follow", 64'(cin_if.ready), 64'(rdy));
    tick();
    cin_if.data_wr = 1'b0;
    cout_if.ready  = 1'b1;
  endtask

  task automatic set_gen(input int g);
    cfg_send(cfg_word(8'd61, 32'h0001_0001, {16'(g), 16'h0000}), 1'b1);
    model_gen = g;
    check("cfg_consumed", 64'(cout_if.data_wr), 0);
  endtask

  task automatic mon_clear();
    got_q.delete();
    phv_cnt = 0; valid_cnt = 0; start_cnt = 0; finish_cnt = 0; both_cnt = 0;
    phv_bad = 0; gap_bad = 0; head_seen = 1'b0; prev_vwr = 1'b0;
    first_head_cyc = 0; tail_cyc = 0;
  endtask

  // Drive one packet (words are random; type bits per position)
  task automatic send_pkt(input int len, input bit keep);
    int n = 0;
    logic [1:0] t;
    while (in_if.alf !== 1'b0 && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) check("input_alf_timeout", 64'(n), 0);
    mon_clear();
    pkt_q.delete();
    for (int i = 0; i < 32; i++) exp_phv[i*32 +: 32] = $urandom;
    for (int i = 0; i < len; i++) begin
      t = (i == 0) ? 2'b01 : ((i == len - 1) ? 2'b10 : 2'b11);
      in_if.data    = rnd_word(t);
      in_if.data_wr = 1'b1;
      pkt_q.push_back(in_if.data);
      if (i == 0) begin
        in_if.phv    = exp_phv;
        in_if.phv_wr = 1'b1;
      end
      if (i == len - 1) begin
        in_if.valid_wr = 1'b1;
        in_if.valid    = keep;
        tail_cyc       = cyc;
      end
      tick();
      in_if.data_wr  = 1'b0;
      in_if.phv_wr   = 1'b0;
      in_if.valid_wr = 1'b0;
      in_if.valid    = 1'b0;
    end
  endtask

  // Reference: a kept packet appears copies times back to back, word for word
  task automatic expect_out(input string tag, input int copies, input bit chk_lat);
    logic [133:0] exp_q [$];
    int n = 0;
    int bad = 0;
    for (int c = 0; c < copies; c++)
      foreach (pkt_q[i]) exp_q.push_back(pkt_q[i]);
    while (got_q.size() < exp_q.size() && n < 5000) begin
      tick();
      n++;
    end
    repeat (10) tick();
    check({tag, "_words"}, 64'(got_q.size()), 64'(exp_q.size()));
    if (got_q.size() == exp_q.size())
      foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) bad++;
    check({tag, "_word_mismatches"}, 64'(bad), 0);
    check({tag, "_phv_wr"}, 64'(phv_cnt), 64'(copies));
    check({tag, "_valid_wr"}, 64'(valid_cnt), 64'(copies));
    check({tag, "_start"}, 64'(start_cnt), (copies > 0) ? 1 : 0);
    check({tag, "_finish"}, 64'(finish_cnt), (copies > 0) ? 1 : 0);
    check({tag, "_phv_value"}, 64'(phv_bad), 0);
    check({tag, "_copy_gap"}, 64'(gap_bad), 0);
    check({tag, "_alf_idle"}, 64'(in_if.alf), 0);
    if (chk_lat && copies > 0)
      check({tag, "_latency"}, 64'(first_head_cyc - tail_cyc), 2);
  endtask

  function automatic int copies_of(input int g);
    return (g == 0) ? 1 : g;
  endfunction

  logic [133:0] fw;
  int g, len;
  bit keep;
  int n;

  initial begin
    rst_n = 1'b1;
    in_if.phv = '0; in_if.phv_wr = 1'b0; in_if.data = '0; in_if.data_wr = 1'b0;
    in_if.valid = 1'b0; in_if.valid_wr = 1'b0;
    out_if.alf = 1'b0; out_if.phv_alf = 1'b0;
    cin_if.data = '0; cin_if.data_wr = 1'b0; cout_if.ready = 1'b1;
    model_gen = 0;
    mon_clear();
    repeat (3) tick();
    check("rst_data_wr", 64'(out_if.data_wr), 0);
    check("rst_phv_wr", 64'(out_if.phv_wr), 0);
    check("rst_alf", 64'(in_if.alf), 0);
    check("rst_cout_wr", 64'(cout_if.data_wr), 0);
    check("rst_flags", 64'({start_flag, finish_flag}), 0);
    rst_n = 1'b0;
    tick();

    // Pass-through with GEN_CNT = 0
    send_pkt(4, 1'b1);
    expect_out("pass4", 1, 1'b1);

    // Config write to this module sets GEN_CNT = 3 and is consumed
    set_gen(3);
    tick();
    check("cfg_consumed_next", 64'(cout_if.data_wr), 0);

    // Other address on this module: ignored, not forwarded
    cfg_send(cfg_word(8'd61, 32'h0002_0000, 32'h0007_0000), 1'b1);
    check("cfg_other_addr", 64'(cout_if.data_wr), 0);

    // Foreign destination forwarded unchanged one cycle later
    fw = cfg_word(8'd62, 32'h0001_0001, 32'h0009_0000);
    cfg_send(fw, 1'b1);
    check("fwd_wr", 64'(cout_if.data_wr), 1);
    check("fwd_data", 64'(cout_if.data === fw), 1);
    tick();
    check("fwd_wr_pulse", 64'(cout_if.data_wr), 0);
    cfg_send(cfg_word(8'd62, 32'h0001_0001, 32'h0009_0000), 1'b0);
    check("fwd_not_ready", 64'(cout_if.data_wr), 0);

    // GEN_CNT = 3 replays the packet three times
    send_pkt(4, 1'b1);
    expect_out("gen3", copies_of(model_gen), 1'b1);

    // Dropped packet, then the next one is accepted
    send_pkt(5, 1'b0);
    expect_out("drop", 0, 1'b0);
    send_pkt(3, 1'b1);
    expect_out("after_drop", copies_of(model_gen), 1'b1);

    // Downstream almost-full holds the packet in WAIT
    set_gen(2);
    out_if.alf = 1'b1;
    send_pkt(3, 1'b1);
    repeat (12) tick();
    check("alf_hold_words", 64'(got_q.size()), 0);
    check("alf_hold_busy", 64'(in_if.alf), 1);
    out_if.alf = 1'b0;
    expect_out("alf_release", copies_of(model_gen), 1'b0);

    // One-word packet: start and finish in the same cycle
    set_gen(0);
    send_pkt(1, 1'b1);
    expect_out("one_word", 1, 1'b1);
    check("one_word_same_cycle", 64'(both_cnt), 1);

    // Full-depth packet kept, one word over depth discarded
    send_pkt(64, 1'b1);
    expect_out("depth64", 1, 1'b1);
    send_pkt(65, 1'b1);
    expect_out("depth65", 0, 1'b0);

    // Randomized packets and generation counts
    for (int k = 0; k < 6; k++) begin
      g    = $urandom_range(0, 3);
      len  = $urandom_range(1, 8);
      keep = ($urandom_range(0, 3) != 0);
      set_gen(g);
      send_pkt(len, keep);
      expect_out($sformatf("rnd%0d", k), keep ? copies_of(g) : 0, 1'b1);
    end

    // Reset during emission aborts the copy without tail or finish
    set_gen(5);
    send_pkt(8, 1'b1);
    n = 0;
    while (got_q.size() < 3 && n < 200) begin
      tick();
      n++;
    end
    check("mid_send_reached", 64'(got_q.size() >= 3), 1);
    rst_n = 1'b1;
    tick();
    check("mid_rst_data_wr", 64'(out_if.data_wr), 0);
    check("mid_rst_valid_wr", 64'(out_if.valid_wr), 0);
    check("mid_rst_phv_wr", 64'(out_if.phv_wr), 0);
    check("mid_rst_alf", 64'(in_if.alf), 0);
    check("mid_rst_finish", 64'(finish_cnt), 0);
    rst_n = 1'b0;
    model_gen = 0;
    tick();
    send_pkt(3, 1'b1);
    expect_out("post_rst", copies_of(model_gen), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
